// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through/no-write-allocate data cache
// controller with zero-wait read hits and a single outstanding memory access.
module dcache_ctrl #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 6,
   parameter int LINES  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_w_en,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [WIDTH-1:0]  cpu_wdata,
   output logic [WIDTH-1:0]  cpu_rdata,
   output logic              cpu_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic              mem_ack,
   input  logic [WIDTH-1:0]  mem_rdata,
   output logic [1:0]        state_dbg
);

   localparam int IDX_W = 3;
   localparam int TAG_W = ADDR_W - IDX_W;

   // Handshake: cpu_req/cpu_* are held by the CPU until cpu_ready pulses for one
   // cycle; mem_req/mem_* are held by this block until mem_ack is seen with mem_req=1.
   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RESP = 2'd2, WRITE = 2'd3} state_t;

   state_t             state_q, state_d;
   logic [LINES-1:0]   valid_q;
   logic [TAG_W-1:0]   tag_mem  [LINES];
   logic [WIDTH-1:0]   data_mem [LINES];
   logic [ADDR_W-1:0]  addr_q;
   logic [WIDTH-1:0]   wdata_q;
   logic [WIDTH-1:0]   fill_q;

   logic [IDX_W-1:0]   cpu_idx, q_idx;
   logic [TAG_W-1:0]   cpu_tag, q_tag;
   logic               cpu_hit, q_hit;
   logic               fill_we, wr_hit_we;

   assign cpu_idx   = cpu_addr[IDX_W-1:0];
   assign cpu_tag   = cpu_addr[ADDR_W-1:IDX_W];
   assign q_idx     = addr_q[IDX_W-1:0];
   assign q_tag     = addr_q[ADDR_W-1:IDX_W];
   assign cpu_hit   = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
   assign q_hit     = valid_q[q_idx] && (tag_mem[q_idx] == q_tag);
   assign state_dbg = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         if (fill_we) valid_q[q_idx] <= 1'b1;
      end
   end

   // Request is captured on acceptance so memory-side outputs stay stable
   // even if the CPU inputs change mid-transaction.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && cpu_req) begin
         addr_q  <= cpu_addr;
         wdata_q <= cpu_wdata;
      end
      if (fill_we) begin
         tag_mem[q_idx]  <= q_tag;
         data_mem[q_idx] <= mem_rdata;
         fill_q          <= mem_rdata;
      end else if (wr_hit_we) begin
         data_mem[q_idx] <= wdata_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      cpu_ready = 1'b0;
      cpu_rdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      fill_we   = 1'b0;
      wr_hit_we = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               if (cpu_w_en) begin
                  state_d = WRITE;
               end else if (cpu_hit) begin
                  cpu_ready = 1'b1;
                  cpu_rdata = data_mem[cpu_idx];
               end else begin
                  state_d = FILL;
               end
            end
         end
         FILL: begin
            mem_req  = 1'b1;
            mem_addr = addr_q;
            if (mem_ack) begin
               fill_we = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            cpu_ready = 1'b1;
            cpu_rdata = fill_q;
            state_d   = IDLE;
         end
         WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            if (mem_ack) begin
               cpu_ready = 1'b1;
               wr_hit_we = q_hit;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a driver task plays CPU and backing memory,
// and each test task checks latencies, data and bus behaviour inline.
module tb_dcache_ctrl;
   localparam int WIDTH = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              cpu_req, cpu_w_en, cpu_ready;
   logic [5:0]        cpu_addr, mem_addr;
   logic [WIDTH-1:0]  cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
   logic              mem_req, mem_we, mem_ack;
   logic [1:0]        state_dbg;

   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] rd, s_wdata;
   int          cyc, reqc;
   logic        s_we, clean;
   logic [5:0]  s_addr;

   dcache_ctrl #(.WIDTH(WIDTH), .ADDR_W(6), .LINES(8)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_w_en(cpu_w_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // One CPU access with a memory responder acking on its lat-th request cycle.
   // cycles = negedge index (from issue) where cpu_ready was seen, -1 on timeout.
   task automatic access(input logic w, input logic [5:0] a, input logic [31:0] wd,
                         input int lat, input logic [31:0] md,
                         output logic [31:0] rdo, output int cycles, output int req_cycles,
                         output logic saw_we, output logic [31:0] saw_wdata,
                         output logic [5:0] saw_addr, output logic ok);
      bit done;
      done = 0; rdo = '0; cycles = -1; req_cycles = 0;
      saw_we = 0; saw_wdata = '0; saw_addr = '0; ok = 1;
      @(posedge clk); #1;
      cpu_req = 1; cpu_w_en = w; cpu_addr = a; cpu_wdata = wd;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (mem_req) begin
            if (req_cycles == 0) begin
               saw_we = mem_we; saw_wdata = mem_wdata; saw_addr = mem_addr;
            end else if (mem_we !== saw_we || mem_wdata !== saw_wdata || mem_addr !== saw_addr) begin
               ok = 0;
            end
            req_cycles++;
            mem_ack = (req_cycles >= lat);
            mem_rdata = md;
         end else if (mem_we !== 1'b0 || mem_addr !== 6'd0 || mem_wdata !== 32'd0) begin
            ok = 0;
         end
         #1;
         if (cpu_ready === 1'b1) begin
            rdo = cpu_rdata; cycles = c; done = 1;
         end else if (cpu_rdata !== 32'd0) begin
            ok = 0;
         end
         @(posedge clk); #1;
         mem_ack = 0; mem_rdata = '0;
      end
      cpu_req = 0; cpu_w_en = 0; cpu_addr = '0; cpu_wdata = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests_run++; if (cpu_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", cpu_ready); end
      tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
      tests_run++; if (cpu_rdata !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 0", cpu_rdata); end
      tests_run++; if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
      @(posedge clk); #1; reset = 0;
   endtask

   task automatic test_read_miss();
      access(0, 6'h05, 0, 3, 32'hDEADBEEF, rd, cyc, reqc, s_we, s_wdata, s_addr, clean);
      tests_run++; if (reqc !== 3) begin tests_failed++; $display("FAIL miss_req_cycles: got %0d expected 3", reqc); end
      tests_run++; if (cyc !== 4) begin tests_failed++; $display("FAIL miss_latency: got %0d expected 4", cyc); end
      tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL miss_rdata: got %h expected deadbeef", rd); end
      tests_run++; if (s_we !== 1'b0 || s_addr !== 6'h05) begin tests_failed++; $display("FAIL miss_bus: got we=%b addr=%h expected we=0 addr=05", s_we, s_addr); end
      tests_run++; if (clean !== 1'b1) begin tests_failed++; $display("FAIL miss_clean: got %b expected 1", clean); end
   endtask

   task automatic test_read_hit();
      access(0, 6'h05, 0, 1, 32'h0BAD0BAD, rd, cyc, reqc, s_we, s_wdata, s_addr, clean);
      tests_run++; if (cyc !== 0) begin tests_failed++; $display("FAIL hit_latency: got %0d expected 0", cyc); end
      tests_run++; if (reqc !== 0) begin tests_failed++; $display("FAIL hit_mem_req: got %0d expected 0", reqc); end
      tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL hit_rdata: got %h expected deadbeef", rd); end
   endtask

   task automatic test_conflict();
      access(0, 6'h0D, 0, 2, 32'h12345678, rd, cyc, reqc, s_we, s_wdata, s_addr, clean);
      tests_run++; if (reqc !== 2 || cyc !== 3) begin tests_failed++; $display("FAIL conflict_fill: got req=%0d lat=%0d expected req=2 lat=3", reqc, cyc); end
      tests_run++; if (rd !== 32'h12345678) begin tests_failed++; $display("FAIL conflict_rdata: got %h expected 12345678", rd); end
      access(0, 6'h05, 0, 1, 32'hAAAA0005, rd, cyc, reqc, s_we, s_wdata, s_addr, clean);
      tests_run++; if (reqc !== 1) begin tests_failed++; $display("FAIL evict_miss: got req=%0d expected 1", reqc); end
      tests_run++; if (rd !== 32'hAAAA0005) begin tests_failed++; $display("FAIL evict_rdata: got %h expected aaaa0005", rd); end
   endtask

   task automatic test_write_hit();
      access(0, 6'h0D, 0, 1, 32'h12345678, rd, cyc, reqc, s_we, s_wdata, s_addr, clean);
      access(1, 6'h0D, 32'hCAFEF00D, 2, 0, rd, cyc, reqc, s_we, s_wdata, s_addr, clean);
      tests_run++; if (cyc !== 2 || reqc !== 2) begin tests_failed++; $display("FAIL wr_latency: got lat=%0d req=%0d expected 2/2", cyc, reqc); end
      tests_run++; if (s_we !== 1'b1 || s_wdata !== 32'hCAFEF00D || s_addr !== 6'h0D) begin tests_failed++; $display("FAIL wr_bus: got we=%b data=%h addr=%h expected 1/cafef00d/0d", s_we, s_wdata, s_addr); end
      tests_run++; if (clean !== 1'b1) begin tests_failed++; $display("FAIL wr_clean: got %b expected 1", clean); end
      access(0, 6'h0D, 0, 1, 32'h0BAD0BAD, rd, cyc, reqc, s_we, s_wdata, s_addr, clean);
      tests_run++; if (cyc !== 0 || rd !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL wr_hit_read: got lat=%0d data=%h expected 0/cafef00d", cyc, rd); end
   endtask

   task automatic test_write_miss();
      access(1, 6'h3F, 32'h1, 1, 0, rd, cyc, reqc, s_we, s_wdata, s_addr, clean);
      tests_run++; if (reqc !== 1 || s_we !== 1'b1 || s_wdata !== 32'h1 || s_addr !== 6'h3F) begin tests_failed++; $display("FAIL wm_bus: got req=%0d we=%b data=%h addr=%h expected 1/1/1/3f", reqc, s_we, s_wdata, s_addr); end
      access(0, 6'h3F, 0, 1, 32'h00000077, rd, cyc, reqc, s_we, s_wdata, s_addr, clean);
      tests_run++; if (reqc !== 1 || rd !== 32'h77) begin tests_failed++; $display("FAIL wm_read_miss: got req=%0d data=%h expected 1/77", reqc, rd); end
      // write miss into an occupied line must not disturb it
      access(1, 6'h15, 32'h99999999, 1, 0, rd, cyc, reqc, s_we, s_wdata, s_addr, clean);
      access(0, 6'h0D, 0, 1, 32'h0BAD0BAD, rd, cyc, reqc, s_we, s_wdata, s_addr, clean);
      tests_run++; if (cyc !== 0 || rd !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL wm_line_kept: got lat=%0d data=%h expected 0/cafef00d", cyc, rd); end
   endtask

   task automatic test_reset_mid_fill();
      @(posedge clk); #1;
      cpu_req = 1; cpu_w_en = 0; cpu_addr = 6'h2A;
      @(negedge clk); @(negedge clk); @(negedge clk);
      tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL rst_fill_req: got %b expected 1", mem_req); end
      #1; reset = 1; mem_ack = 1; mem_rdata = 32'h55555555; #1;
      tests_run++; if (mem_req !== 1'b0 || state_dbg !== 2'd0 || cpu_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_abandon: got req=%b state=%0d ready=%b expected 0/0/0", mem_req, state_dbg, cpu_ready); end
      cpu_req = 0; cpu_addr = '0;
      @(posedge clk); #1; mem_ack = 0;
      @(posedge clk); #1; reset = 0; mem_ack = 1;
      @(negedge clk);
      tests_run++; if (mem_req !== 1'b0 || cpu_ready !== 1'b0 || state_dbg !== 2'd0) begin tests_failed++; $display("FAIL spurious_ack: got req=%b ready=%b state=%0d expected 0/0/0", mem_req, cpu_ready, state_dbg); end
      @(posedge clk); #1; mem_ack = 0;
      access(0, 6'h2A, 0, 2, 32'h600D600D, rd, cyc, reqc, s_we, s_wdata, s_addr, clean);
      tests_run++; if (reqc !== 2 || rd !== 32'h600D600D) begin tests_failed++; $display("FAIL rst_remiss: got req=%0d data=%h expected 2/600d600d", reqc, rd); end
      access(0, 6'h0D, 0, 1, 32'h0000ABCD, rd, cyc, reqc, s_we, s_wdata, s_addr, clean);
      tests_run++; if (reqc !== 1 || rd !== 32'hABCD) begin tests_failed++; $display("FAIL rst_cleared: got req=%0d data=%h expected 1/0000abcd", reqc, rd); end
   endtask

   initial begin
      reset = 1; cpu_req = 0; cpu_w_en = 0; cpu_addr = '0; cpu_wdata = '0;
      mem_ack = 0; mem_rdata = '0;
      repeat (3) @(posedge clk);
      test_reset();
      test_read_miss();
      test_read_hit();
      test_conflict();
      test_write_hit();
      test_write_miss();
      test_reset_mid_fill();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 6, word address width; this is fixed at 6.
REQ-003 SHALL have parameter LINES, default 8, number of one-word direct-mapped lines; this is fixed at 8.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cpu_req  input  1  CPU access valid; CPU holds all cpu_* inputs stable until cpu_ready.
REQ-007 SHALL have port cpu_w_en  input  1  1 = store, 0 = load.
REQ-008 SHALL have port cpu_addr  input  6  word address.
REQ-009 SHALL have port cpu_wdata  input  WIDTH  store data.
REQ-010 SHALL have port cpu_rdata  output  WIDTH  load data, valid when cpu_ready=1 and cpu_w_en=0.
REQ-011 SHALL have port cpu_ready  output  1  one-cycle pulse marking access completion.
REQ-012 SHALL have port mem_req  output  1  backing-memory request.
REQ-013 SHALL have port mem_we  output  1  backing-memory write strobe.
REQ-014 SHALL have port mem_addr  output  6  backing-memory word address.
REQ-015 SHALL have port mem_wdata  output  WIDTH  backing-memory write data.
REQ-016 SHALL have port mem_ack  input  1  backing-memory completion, sampled only while mem_req=1.
REQ-017 SHALL have port mem_rdata  input  WIDTH  fill data, valid in the mem_ack cycle.

Function
REQ-018 SHALL split cpu_addr into index = cpu_addr[2:0] and tag = cpu_addr[5:3], storing a valid bit, a 3-bit tag and one data word per line.
REQ-019 SHALL implement FSM states IDLE, FILL, RESP and WRITE.
REQ-020 IDLE, cpu_req=1, cpu_w_en=0, hit: SHALL assert cpu_ready and drive the line data on cpu_rdata combinationally in the same cycle (zero-wait hit), and SHALL remain in IDLE.
REQ-021 IDLE, read miss: SHALL go to FILL on the next edge.
REQ-022 FILL: SHALL drive mem_req=1, mem_we=0, mem_addr=cpu_addr until mem_ack.
REQ-023 On mem_ack in FILL, SHALL write the line (valid=1, tag, mem_rdata) and register mem_rdata, then go to RESP.
REQ-024 RESP: SHALL assert cpu_ready for one cycle with cpu_rdata = the registered fill data, then return to IDLE.
REQ-025 IDLE, cpu_req=1, cpu_w_en=1: SHALL go to WRITE (write-through, no write-allocate).
REQ-026 WRITE: SHALL drive mem_req=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata until mem_ack.
REQ-027 In the mem_ack cycle of WRITE, SHALL assert cpu_ready, update the line data only if it is a hit, and return to IDLE.
REQ-028 A write miss SHALL leave the line's valid, tag and data unchanged.
REQ-029 SHALL ignore mem_ack while mem_req=0.
REQ-030 SHALL hold mem_addr, mem_we and mem_wdata stable while mem_req=1.
REQ-031 Minimum latencies: read hit 0 cycles; read miss = memory latency + 1 cycle; write = memory latency.
REQ-032 SHALL drive mem_req, mem_we, mem_addr and mem_wdata to 0 in IDLE and RESP.
REQ-033 SHALL drive cpu_rdata to 0 whenever cpu_ready=0.
REQ-034 Once a transaction has left IDLE, it SHALL run to completion even if cpu_req drops, and cpu_ready SHALL still pulse.
REQ-035 SHALL not accept a new access in the cycle cpu_ready pulses from RESP or WRITE; the next access is evaluated in IDLE.

Reset
REQ-036 While reset=1, SHALL force the state to IDLE, clear all valid bits, and drive cpu_ready, cpu_rdata and all mem_* outputs to 0, taking effect immediately without waiting for clk.
REQ-037 Reset asserted during FILL or WRITE SHALL abandon the transaction, deassert mem_req at once, and leave no line written.
REQ-038 After reset, the first access to any address SHALL miss.

Verification
REQ-039 Reset, then read addr 0x05 with memory returning 0xDEADBEEF after 3 cycles -> mem_req high 3 cycles, cpu_ready one cycle later with cpu_rdata=0xDEADBEEF.
REQ-040 Read 0x05 again -> cpu_ready in the same cycle, cpu_rdata=0xDEADBEEF, mem_req stays 0.
REQ-041 Read 0x0D (same index 5, tag 1) with memory returning 0x12345678 -> miss and fill; a following read of 0x05 misses again (conflict eviction).
REQ-042 Write 0x0D=0xCAFEF00D (hit) with mem_ack after 2 cycles -> mem_we=1, mem_wdata=0xCAFEF00D, cpu_ready in the ack cycle; a following read of 0x0D hits and returns 0xCAFEF00D.
REQ-043 Write 0x3F=0x1 (miss) -> memory written; a following read of 0x3F misses.
REQ-044 Assert reset in the second FILL cycle -> mem_req=0 immediately; after release, a read of the same address misses, and a spurious mem_ack is ignored.
